// File: rtl/core_boot_pkg.sv
// core_boot_pkg: boot loader FSM encoding and stream framing constants.
package core_boot_pkg;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} boot_state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/boot_word_pack.sv
// boot_word_pack: assembles little-endian bytes into 32-bit words with a one-cycle word_valid.
module boot_word_pack
  import core_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [23:0] part;
  logic        last;
  assign last = lane == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      part       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && last;
      if (byte_en) begin
        lane <= lane + 2'd1;
        part <= {byte_in, part[23:8]};
        if (last) word <= {byte_in, part};
      end
    end
  end
endmodule

// File: rtl/core_boot_loader.sv
// core_boot_loader: streams a length-prefixed image into instruction SRAM, then releases core reset.
// Define BOOT_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module core_boot_loader
  import core_boot_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              core_rst_n,
  output logic              boot_done,
  output logic              boot_err
);
  localparam logic [ADDR_W:0] ONE = 1;
  boot_state_t     state;
  logic [7:0]      len_lo;
  logic [ADDR_W:0] n_words, word_cnt;
  logic [15:0]     len;
  logic [1:0]      lane;
  logic            accept, byte_en, last_word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]      sum;
`endif
  assign accept    = in_valid & in_ready;
  assign byte_en   = accept & (state == DATA);
  assign len       = {in_data, len_lo};
  assign last_word = word_cnt == n_words - ONE;

  boot_word_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .lane       (lane),
    .word       (sram_wdata),
    .word_valid (sram_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LEN_LO;
      len_lo     <= '0;
      n_words    <= '0;
      word_cnt   <= '0;
      sram_addr  <= '0;
      in_ready   <= 1'b0;
      core_rst_n <= 1'b0;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        LEN_LO: begin
          in_ready <= 1'b1;
          if (accept) begin
            len_lo <= in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: if (accept) begin
          n_words <= len[ADDR_W:0];
          if (len > 16'(2 ** ADDR_W)) begin
            state    <= ERR;
            in_ready <= 1'b0;
            boot_err <= 1'b1;
          end else if (len == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
            state      <= CSUM;
`else
            state      <= DONE;
            in_ready   <= 1'b0;
            boot_done  <= 1'b1;
            core_rst_n <= 1'b1;
`endif
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          if (byte_en) begin
`ifdef BOOT_CHECKSUM_EN
            sum <= sum + in_data;
`endif
            if (lane == 2'(BYTES_PER_WORD - 1)) begin
              sram_addr <= word_cnt[ADDR_W-1:0];
              word_cnt  <= word_cnt + ONE;
`ifdef BOOT_CHECKSUM_EN
              if (last_word) state <= CSUM;
`else
              if (last_word) in_ready <= 1'b0;
`endif
            end
          end
`ifndef BOOT_CHECKSUM_EN
          // Finish one edge after the final byte so DONE follows the last write
          if (word_cnt == n_words) begin
            state      <= DONE;
            boot_done  <= 1'b1;
            core_rst_n <= 1'b1;
          end
`endif
        end
`ifdef BOOT_CHECKSUM_EN
        CSUM: if (accept) begin
          in_ready <= 1'b0;
          if (in_data == sum) begin
            state      <= DONE;
            boot_done  <= 1'b1;
            core_rst_n <= 1'b1;
          end else begin
            state    <= ERR;
            boot_err <= 1'b1;
          end
        end
`endif
        default: in_ready <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_core_boot_loader.sv
// tb_core_boot_loader: directed streams with hand-computed writes, timing and status checks.
module tb_core_boot_loader;
  localparam int ADDR_W = 10;
  logic              clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready, sram_we, core_rst_n, boot_done, boot_err;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;

  core_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .core_rst_n (core_rst_n),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, we_dbl = 0;
  logic we_prev = 1'b0;
  logic [7:0]        img[$];
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  always @(negedge clk) begin
    if (sram_we) begin
      wa.push_back(sram_addr);
      wd.push_back(sram_wdata);
      if (we_prev) we_dbl++;
    end
    we_prev = sram_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) check("ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_img(input int lo, input int hi, input bit rnd);
    for (int i = lo; i < hi; i++) send_byte(img[i], rnd ? int'($urandom_range(0, 3)) : 0);
  endtask

  function automatic logic [7:0] psum();
    logic [7:0] s = '0;
    for (int i = 2; i < img.size(); i++) s += img[i];
    return s;
  endfunction

  task automatic send_csum();
`ifdef BOOT_CHECKSUM_EN
    send_byte(psum(), 0);
`endif
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wa.delete();
    wd.delete();
    we_dbl = 0;
    rst_n = 1'b1;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_we", sram_we, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_wdata, 0);
    check("rst_core", core_rst_n, 0);
    check("rst_done", boot_done, 0);
    check("rst_err", boot_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", in_ready, 1);

    // single word, write timing and done edge
    img = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    send_img(0, 6, 1'b0);
    check("t1_we", sram_we, 1);
    check("t1_addr", sram_addr, 0);
    check("t1_data", sram_wdata, 32'h00A00513);
`ifdef BOOT_CHECKSUM_EN
    check("t1_csum_val", psum(), 8'hB8);
    send_csum();
`else
    check("t1_done_early", boot_done, 0);
    @(posedge clk); #1;
`endif
    check("t1_done", boot_done, 1);
    check("t1_core", core_rst_n, 1);
    check("t1_we_off", sram_we, 0);
    settle();
    check("t1_ready", in_ready, 0);
    check("t1_err", boot_err, 0);
    check("t1_nwr", wa.size(), 1);

    // three words with random valid gaps
    reset_dut();
    img = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
            8'h01, 8'h00, 8'h00, 8'h00};
    send_img(0, 14, 1'b1);
    send_csum();
    settle();
    check("t2_nwr", wa.size(), 3);
    check("t2_a0", wa[0], 0);
    check("t2_d0", wd[0], 32'h11223344);
    check("t2_a1", wa[1], 1);
    check("t2_d1", wd[1], 32'hDEADBEEF);
    check("t2_a2", wa[2], 2);
    check("t2_d2", wd[2], 32'h00000001);
    check("t2_pulse", we_dbl, 0);
    check("t2_done", boot_done, 1);

    // length overflow
    reset_dut();
    img = '{8'h01, 8'h04};
    send_img(0, 2, 1'b0);
    settle();
    check("t3_err", boot_err, 1);
    check("t3_done", boot_done, 0);
    check("t3_core", core_rst_n, 0);
    check("t3_ready", in_ready, 0);
    check("t3_nwr", wa.size(), 0);

    // empty image
    reset_dut();
    img = '{8'h00, 8'h00};
    send_img(0, 2, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    check("t4_done_early", boot_done, 0);
    send_byte(8'h00, 0);
`endif
    check("t4_done", boot_done, 1);
    check("t4_core", core_rst_n, 1);
    settle();
    check("t4_nwr", wa.size(), 0);

`ifdef BOOT_CHECKSUM_EN
    // bad checksum
    reset_dut();
    img = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    send_img(0, 6, 1'b0);
    send_byte(8'hB9, 0);
    settle();
    check("t5_err", boot_err, 1);
    check("t5_core", core_rst_n, 0);
    check("t5_done", boot_done, 0);
    check("t5_nwr", wa.size(), 1);
    check("t5_addr", wa[0], 0);
`endif

    // reset mid-load then full resend
    reset_dut();
    img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h9A};
    send_img(0, 8, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_core", core_rst_n, 0);
    check("t6_rst_ready", in_ready, 0);
    reset_dut();
    send_img(0, 10, 1'b1);
    send_csum();
    settle();
    check("t6_nwr", wa.size(), 2);
    check("t6_d0", wd[0], 32'h12345678);
    check("t6_d1", wd[1], 32'h9ABCDEF0);
    check("t6_a1", wa[1], 1);
    check("t6_done", boot_done, 1);

    // maximum legal image: 1024 words, last address 0x3FF
    reset_dut();
    img = '{8'h00, 8'h04};
    for (int i = 0; i < 4096; i++) img.push_back(8'(i));
    send_img(0, img.size(), 1'b0);
    send_csum();
    settle();
    check("t7_nwr", wa.size(), 1024);
    check("t7_d0", wd[0], 32'h03020100);
    check("t7_alast", wa[1023], 10'h3FF);
    check("t7_dlast", wd[1023], 32'hFFFEFDFC);
    check("t7_done", boot_done, 1);
    check("t7_err", boot_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/core_boot_loader.md
# core_boot_loader

Streams a program image from a byte-wide valid/ready source into the core's instruction SRAM after reset, then releases the core's reset. It sits directly upstream of the pipeline top: its `core_rst_n` drives the pipeline's reset, and its SRAM write port feeds the instruction memory. The byte source is typically a UART receiver or a bench driver. It runs on the pipeline clock domain.

## Interface
- `ADDR_W`, 10: SRAM word-address width; maximum image size is 2^ADDR_W words.
- `clk`  in  1  pipeline clock (`pipe_clk` domain); all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  image byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte. Reset value 0.
- `sram_we`  out  1  one-cycle word write strobe. Reset value 0.
- `sram_addr`  out  ADDR_W  word address. Reset value 0.
- `sram_wdata`  out  32  word data. Reset value 0.
- `core_rst_n`  out  1  reset to the pipeline; low until the load succeeds. Reset value 0.
- `boot_done`  out  1  image loaded; sticky. Reset value 0.
- `boot_err`  out  1  load failed; sticky. Reset value 0.

## Operation
- A byte is accepted at a rising edge where `in_valid & in_ready`. All outputs are registered.
- Stream format:
  - `LEN_LO`, `LEN_HI`: 16-bit word count N, little-endian.
  - N×4 payload bytes, little-endian within each word (the first byte goes to `[7:0]`).
  - Optional checksum byte (see Configuration).
- FSM states and transitions:
  - `LEN_LO` → `LEN_HI` on accept.
  - `LEN_HI` on accept:
    - If N > 2^ADDR_W → `ERR`.
    - If N == 0 → `CSUM` (macro set) or `DONE`.
    - Otherwise → `DATA`.
  - `DATA`: a 2-bit byte counter and a word counter run.
    - On acceptance of byte 3, the assembled word is written at address = word counter, and the word counter increments.
    - After word N-1 → `CSUM` or `DONE`.
  - `CSUM` → `DONE` if the received byte equals the payload sum; otherwise → `ERR`.
  - `DONE` and `ERR` are terminal. Only `rst_n` exits them.
- `in_ready` is 1 in `LEN_LO`, `LEN_HI`, `DATA`, `CSUM` and 0 in `DONE` and `ERR`. The loader never stalls the source while active.
- `in_valid` low mid-word holds the partial word and counters indefinitely; there is no timeout.
- Word counter width is ADDR_W+1, so N = 2^ADDR_W is legal. The last address written is 2^ADDR_W−1, with no wrap.
- `core_rst_n` rises only in `DONE` and remains low in `ERR`.
- Asserting `rst_n` mid-load clears all state, forces `core_rst_n` low, and restarts at `LEN_LO`. SRAM contents are not cleared.

## Timing
- `in_ready` goes high on the first rising edge after `rst_n` deasserts.
- Write latency is 1 cycle. `sram_we`, `sram_addr` and `sram_wdata` are valid for exactly the one cycle following the edge that accepted byte 3. `sram_we` is 0 in all other cycles.
- Back-to-back bytes give one write every 4 cycles.
- `boot_done` and `core_rst_n` rise together on the edge that enters `DONE`:
  - the edge after the last write, or
  - the checksum-accept edge.
- `boot_err` rises on the edge entering `ERR`.
- Total latency with a continuous stream: 2 + 4N (+1) cycles, then 1 more cycle to `core_rst_n` high.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - Adds the `CSUM` state and an 8-bit running sum (mod 256) over all payload bytes; the sum excludes the length bytes.
  - A mismatch → `ERR`, with `core_rst_n` held low.
- Undefined:
  - No checksum byte is expected; the sum register is absent.
  - The final payload byte leads straight to `DONE`.
  - `boot_err` can be set only by a length overflow.

## Structure
- Shared package `core_boot_pkg` holds:
  - the FSM state encoding (`LEN_LO`, `LEN_HI`, `DATA`, `CSUM`, `DONE`, `ERR`);
  - `HDR_BYTES = 2`;
  - `BYTES_PER_WORD = 4`.
- One sub-module, `boot_word_pack`: a byte-to-word assembler with the 2-bit lane counter. It emits a 32-bit word plus a one-cycle `word_valid`. The FSM, counters, checksum and outputs stay in `core_boot_loader`.

## Test plan
- Stream `01 00 13 05 A0 00` (checksum byte `B8` if enabled) → one write: addr 0, data `0x00A00513`. Then `boot_done` = 1 and `core_rst_n` = 1, and `in_ready` = 0 thereafter.
- N = 3, with `in_valid` toggling randomly → writes at addr 0, 1, 2 in order, each `sram_we` exactly one cycle. The data matches the little-endian words.
- Length bytes `01 04` (N = 1025, ADDR_W = 10) → `boot_err` = 1, no `sram_we`, `core_rst_n` stays 0.
- N = 0 → no writes; `DONE` on the next edge (without the macro) or after the checksum byte `00`.
- With `BOOT_CHECKSUM_EN`, the first test with checksum `B9` → `boot_err` = 1 and `core_rst_n` = 0. The write to addr 0 has still occurred.
- `rst_n` pulsed after 6 of 8 payload bytes, then the full stream resent → the loader restarts at `LEN_LO`, both words are written correctly, and `boot_done` = 1.
